cache_victim_lfsr: RTL and testbench
====================================

CACHE_VICTIM_LFSR -- requirements
Module: cache_victim_lfsr

Interface
REQ-001 SHALL have parameter NUMWAYS, default 4: ways per set; power of 2, range 1..16.
REQ-002 SHALL have parameter LFSRLEN, default 4: LFSR width; range max(3, log2(NUMWAYS)+2)..16.
REQ-003 SHALL have parameter SEED, default all-ones: reset/reload value; a zero SEED is a parameter error.
REQ-004 SHALL have parameter MODE, default 0: 0 = LFSR random, 1 = round-robin counter.
REQ-005 SHALL have port clk  in  1  clock; the block uses one clock.
REQ-006 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have port FlushStage  in  1  stage flush; suppresses advance and reload.
REQ-008 SHALL have port ValidWay  in  NUMWAYS  valid bits of the addressed set.
REQ-009 SHALL have port LockWay  in  NUMWAYS  ways excluded from victim selection.
REQ-010 SHALL have port LRUWriteEn  in  1  replacement-state update strobe.
REQ-011 SHALL have port SetValid  in  1  line fill in progress; qualifies advance.
REQ-012 SHALL have port InvalidateCache  in  1  reloads SEED.
REQ-013 SHALL have ports SeedLoad  in  1  and SeedVal  in  LFSRLEN: test seed load.
REQ-014 SHALL have port VictimWay  out  NUMWAYS  one-hot victim, or zero when there is no victim.
REQ-015 SHALL have port NoVictim  out  1  asserted when all ways are locked.
REQ-016 SHALL have port RandState  out  LFSRLEN  current state register value.

Function
REQ-017 SHALL hold state register Q (LFSRLEN bits).
REQ-018 SHALL set Advance = LRUWriteEn & SetValid & ~FlushStage.
REQ-019 SHALL, in MODE 0 on Advance, load Q <= {fb, Q[LFSRLEN-1:1]}, where fb = XOR of Q[i] for bits set in TAPS[LFSRLEN].
REQ-020 SHALL, in MODE 1 on Advance, load Q <= Q+1 modulo NUMWAYS, with the upper bits held at zero.
REQ-021 SHALL derive candidate index C = Q[log2(NUMWAYS)-1:0].
REQ-022 SHALL, when the set Free = ~ValidWay & ~LockWay is nonzero, make VictimWay the lowest-index set bit of Free.
REQ-023 SHALL otherwise make VictimWay the first unlocked way found scanning from C upward, wrapping past NUMWAYS-1 to 0.
REQ-024 SHALL, when all ways are locked, drive VictimWay = 0 and NoVictim = 1; Advance still updates Q.
REQ-025 SHALL compute VictimWay and NoVictim combinationally from current Q and inputs, with zero-cycle latency.
REQ-026 SHALL apply Q-update priority reset_n low > SeedLoad > (InvalidateCache & ~FlushStage) > Advance > hold.
REQ-027 SHALL load Q <= SeedVal on SeedLoad, except that SeedVal = 0 in MODE 0 loads SEED (lock-up avoidance).
REQ-028 SHALL, on (InvalidateCache & ~FlushStage), load Q <= SEED in MODE 0 or 0 in MODE 1.
REQ-029 SHALL, in MODE 0, never reach Q = 0; if Q = 0 is detected, force Q <= SEED on the next edge.
REQ-030 SHALL, when NUMWAYS = 1, drive VictimWay = ~LockWay[0] and NoVictim = LockWay[0].
REQ-031 SHALL give every TAPS entry a maximal period of 2^LFSRLEN-1.

Reset
REQ-032 SHALL, on a clk edge with reset_n low, set Q to SEED in MODE 0 or 0 in MODE 1, overriding all other inputs.
REQ-033 SHALL have outputs after reset that follow REQ-022..024 from the reset Q; reset asserted mid-fill discards the pending Advance.

Structure
REQ-034 SHALL place the TAPS table (indexed 3..16), the MODE encodings and the default SEED in shared package cache_repl_pkg.
REQ-035 SHALL implement the wrap-around scan (REQ-023) in sub-module rotate_priority_onehot (parameter N; inputs req, start; output grant).
REQ-036 SHALL reject illegal NUMWAYS/LFSRLEN/SEED combinations with an elaboration-time assertion.

Verification (NUMWAYS=4, LFSRLEN=4, TAPS[4]=4'b0011, SEED=4'b1111, MODE 0)
REQ-037 SHALL cover: reset, ValidWay=1111, LockWay=0 -> Q=1111, VictimWay=1000; after 3 Advances Q=0001, VictimWay=0010; after 15 Advances Q=1111.
REQ-038 SHALL cover: ValidWay=1011, LockWay=0000 -> VictimWay=0100 regardless of Q; ValidWay=1011, LockWay=0100 -> random path used.
REQ-039 SHALL cover: Q=1111, ValidWay=1111, LockWay=1000 -> VictimWay=0001 (wrap); LockWay=1111 -> VictimWay=0000, NoVictim=1.
REQ-040 SHALL cover: Advance together with FlushStage=1 -> Q unchanged; SeedLoad with SeedVal=0 -> Q=1111; SeedLoad together with InvalidateCache, SeedVal=0101 -> Q=0101.
REQ-041 SHALL cover: MODE 1, 5 Advances from reset -> Q=1, VictimWay=0010; InvalidateCache -> Q=0.
REQ-042 SHALL cover: reset_n low in the same cycle as Advance -> Q=1111 next cycle; 10k random cycles -> VictimWay always one-hot or zero, never a locked way.

Source files
------------

// File: rtl/cache_repl_pkg.sv
// Shared replacement-policy constants: mode encodings, default seed and the
// maximal-length LFSR tap table used by the victim selector.
package cache_repl_pkg;

  localparam int MODE_LFSR = 0;
  localparam int MODE_RR   = 1;

  localparam int TAPS_MIN_LEN = 3;
  localparam int TAPS_MAX_LEN = 16;

  // All-ones reload value; the top slices it down to its own state width.
  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

  // Tap masks for a right-shifting register whose new MSB is the XOR of the
  // masked bits. Bit i set means x^i appears in the primitive polynomial
  // x^L + ... + 1, so every entry cycles through 2^L-1 nonzero states.
  localparam logic [15:0] TAPS [3:16] = '{
    16'h0003,  //  3: x^3+x+1
    16'h0003,  //  4: x^4+x+1
    16'h0005,  //  5: x^5+x^2+1
    16'h0003,  //  6: x^6+x+1
    16'h0003,  //  7: x^7+x+1
    16'h001D,  //  8: x^8+x^4+x^3+x^2+1
    16'h0011,  //  9: x^9+x^4+1
    16'h0009,  // 10: x^10+x^3+1
    16'h0005,  // 11: x^11+x^2+1
    16'h0053,  // 12: x^12+x^6+x^4+x+1
    16'h001B,  // 13: x^13+x^4+x^3+x+1
    16'h0443,  // 14: x^14+x^10+x^6+x+1
    16'h0003,  // 15: x^15+x+1
    16'h100B   // 16: x^16+x^12+x^3+x+1
  };

endpackage

// File: rtl/rotate_priority_onehot.sv
// Rotating priority picker: grants the first requesting bit found when
// scanning upward from 'start', wrapping from N-1 back to 0. Zero grant when
// nothing requests. N must be a power of two so the index wraps for free.
module rotate_priority_onehot #(
  parameter int N = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  grant
);

  if (N == 1) begin : g_single
    assign grant = req;
  end else begin : g_scan
    logic [SW-1:0] idx_s;
    logic          found_s;

    // Walk the ways from start; SW-bit index arithmetic wraps modulo N.
    always_comb begin
      grant   = '0;
      found_s = 1'b0;
      idx_s   = start;
      for (int i = 0; i < N; i++) begin
        idx_s        = start + SW'(i);
        grant[idx_s] = req[idx_s] & ~found_s;
        found_s      = found_s | req[idx_s];
      end
    end
  end

endmodule

// File: rtl/cache_victim_lfsr.sv
// Cache victim-way selector. Invalid unlocked ways are filled first (lowest
// index); otherwise a pseudo-random (LFSR) or round-robin candidate picks the
// starting point of a wrap-around scan over the unlocked ways.
module cache_victim_lfsr
  import cache_repl_pkg::*;
#(
  parameter int                 NUMWAYS = 4,
  parameter int                 LFSRLEN = 4,
  parameter logic [LFSRLEN-1:0] SEED    = SEED_DEFAULT[LFSRLEN-1:0],
  parameter int                 MODE    = MODE_LFSR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] LockWay,
  input  logic               LRUWriteEn,
  input  logic               SetValid,
  input  logic               InvalidateCache,
  input  logic               SeedLoad,
  input  logic [LFSRLEN-1:0] SeedVal,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               NoVictim,
  output logic [LFSRLEN-1:0] RandState
);

  localparam int WAY_BITS = $clog2(NUMWAYS);
  localparam int IDXW     = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam int MIN_LEN  = ((WAY_BITS + 2) > TAPS_MIN_LEN) ? (WAY_BITS + 2) : TAPS_MIN_LEN;
  localparam bit IS_LFSR  = (MODE == MODE_LFSR);

  // Value taken on reset and on cache invalidation.
  localparam logic [LFSRLEN-1:0] RELOAD_VAL = IS_LFSR ? SEED : {LFSRLEN{1'b0}};
  localparam logic [LFSRLEN-1:0] TAP_MASK   = TAPS[LFSRLEN][LFSRLEN-1:0];

  if ((NUMWAYS < 1) || (NUMWAYS > 16) || ((NUMWAYS & (NUMWAYS - 1)) != 0) ||
      (LFSRLEN < MIN_LEN) || (LFSRLEN > TAPS_MAX_LEN) ||
      (SEED == {LFSRLEN{1'b0}}) ||
      ((MODE != MODE_LFSR) && (MODE != MODE_RR))) begin : g_param_check
    $error("cache_victim_lfsr: illegal parameters NUMWAYS=%0d LFSRLEN=%0d MODE=%0d",
           NUMWAYS, LFSRLEN, MODE);
  end

  logic [LFSRLEN-1:0] rand_q;
  logic [LFSRLEN-1:0] rand_d;
  logic [LFSRLEN-1:0] lfsr_next_s;
  logic [LFSRLEN-1:0] rr_next_s;
  logic               advance_s;
  logic               fb_s;

  assign advance_s = LRUWriteEn & SetValid & ~FlushStage;

  // Candidate successors for both policies.
  always_comb begin
    fb_s        = ^(rand_q & TAP_MASK);
    lfsr_next_s = {fb_s, rand_q[LFSRLEN-1:1]};
    rr_next_s   = '0;
    if (NUMWAYS > 1) begin
      rr_next_s[IDXW-1:0] = rand_q[IDXW-1:0] + IDXW'(1);
    end else begin
      rr_next_s = '0;
    end
  end

  // Next-state priority: seed load, invalidate, lock-up recovery, advance, hold.
  always_comb begin
    rand_d = rand_q;
    if (SeedLoad) begin
      if (IS_LFSR && (SeedVal == {LFSRLEN{1'b0}})) begin
        rand_d = SEED;
      end else begin
        rand_d = SeedVal;
      end
    end else if (InvalidateCache && !FlushStage) begin
      rand_d = RELOAD_VAL;
    end else if (IS_LFSR && (rand_q == {LFSRLEN{1'b0}})) begin
      rand_d = SEED;
    end else if (advance_s) begin
      rand_d = IS_LFSR ? lfsr_next_s : rr_next_s;
    end else begin
      rand_d = rand_q;
    end
  end

  // State register with synchronous active-low reset; reset drops any advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rand_q <= RELOAD_VAL;
    end else begin
      rand_q <= rand_d;
    end
  end

  assign RandState = rand_q;

  if (NUMWAYS == 1) begin : g_one_way
    assign VictimWay = ~LockWay;
    assign NoVictim  = LockWay[0];
  end else begin : g_multi_way
    logic [NUMWAYS-1:0] free_s;
    logic [NUMWAYS-1:0] free_low_s;
    logic [NUMWAYS-1:0] scan_grant_s;

    rotate_priority_onehot #(
      .N (NUMWAYS)
    ) u_scan (
      .req   (~LockWay),
      .start (rand_q[IDXW-1:0]),
      .grant (scan_grant_s)
    );

    // Prefer the lowest free way; otherwise scan unlocked ways from the candidate.
    always_comb begin
      free_s     = ~ValidWay & ~LockWay;
      free_low_s = free_s & (~free_s + NUMWAYS'(1));
      if (free_s != '0) begin
        VictimWay = free_low_s;
      end else begin
        VictimWay = scan_grant_s;
      end
      NoVictim = &LockWay;
    end
  end

endmodule

// File: tb/tb_cache_victim_lfsr.sv
// Directed bench for cache_victim_lfsr: LFSR instance (MODE 0) and round-robin
// instance (MODE 1) share stimulus; expectations are hand-computed.
module tb_cache_victim_lfsr;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       FlushStage;
  logic [3:0] ValidWay;
  logic [3:0] LockWay;
  logic       LRUWriteEn;
  logic       SetValid;
  logic       InvalidateCache;
  logic       SeedLoad;
  logic [3:0] SeedVal;

  logic [3:0] victim_l, victim_r;
  logic       novic_l, novic_r;
  logic [3:0] q_l, q_r;

  int checks = 0;
  int errors = 0;

  // x^4+x+1 sequence starting after 4'b1111
  logic [3:0] exp_seq [0:14] = '{
    4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0100,
    4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
    4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111
  };

  always #5 clk = ~clk;

  cache_victim_lfsr #(.NUMWAYS(4), .LFSRLEN(4), .SEED(4'b1111), .MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .FlushStage(FlushStage), .ValidWay(ValidWay),
    .LockWay(LockWay), .LRUWriteEn(LRUWriteEn), .SetValid(SetValid),
    .InvalidateCache(InvalidateCache), .SeedLoad(SeedLoad), .SeedVal(SeedVal),
    .VictimWay(victim_l), .NoVictim(novic_l), .RandState(q_l)
  );

  cache_victim_lfsr #(.NUMWAYS(4), .LFSRLEN(4), .SEED(4'b1111), .MODE(1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .FlushStage(FlushStage), .ValidWay(ValidWay),
    .LockWay(LockWay), .LRUWriteEn(LRUWriteEn), .SetValid(SetValid),
    .InvalidateCache(InvalidateCache), .SeedLoad(SeedLoad), .SeedVal(SeedVal),
    .VictimWay(victim_r), .NoVictim(novic_r), .RandState(q_r)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal(input logic [3:0] v, input logic nv, input logic [3:0] q,
                                 input logic chk_q);
    logic [3:0] fr;
    logic [3:0] lo;
    logic       ok;
    fr = ~ValidWay & ~LockWay;
    lo = fr & (~fr + 4'd1);
    ok = ((v & (v - 4'd1)) == 4'd0) && ((v & LockWay) == 4'd0) && (nv === (&LockWay));
    if (fr != 4'd0) ok = ok && (v == lo);
    else if (&LockWay) ok = ok && (v == 4'd0);
    else ok = ok && (v != 4'd0);
    if (chk_q) ok = ok && (q != 4'd0);
    return ok;
  endfunction

  initial begin
    reset_n = 1'b0; FlushStage = 1'b0; ValidWay = 4'b0; LockWay = 4'b0;
    LRUWriteEn = 1'b0; SetValid = 1'b0; InvalidateCache = 1'b0;
    SeedLoad = 1'b0; SeedVal = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1; ValidWay = 4'b1111; LockWay = 4'b0000;
    #1;
    check("rst_q",        q_l, 4'b1111);
    check("rst_victim",   victim_l, 4'b1000);
    check("rst_novictim", {3'b000, novic_l}, 4'b0000);
    check("rr_rst_q",     q_r, 4'b0000);
    check("rr_rst_victim", victim_r, 4'b0001);

    // full LFSR period
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("lfsr_seq", q_l, exp_seq[i]);
      check("rr_seq", q_r, 4'((i + 1) % 4));
      if (i == 2) check("victim_after3", victim_l, 4'b0010);
    end
    LRUWriteEn = 1'b0; SetValid = 1'b0;

    // free way beats the random candidate
    ValidWay = 4'b1011; LockWay = 4'b0000;
    #1;
    check("free_q1111", victim_l, 4'b0100);
    check("rr_free", victim_r, 4'b0100);
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    repeat (2) tick();
    LRUWriteEn = 1'b0; SetValid = 1'b0;
    check("q_0011", q_l, 4'b0011);
    check("free_q0011", victim_l, 4'b0100);
    LockWay = 4'b0100;
    #1;
    check("rand_c3", victim_l, 4'b1000);
    check("rr_rand_c1", victim_r, 4'b0010);
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    repeat (2) tick();
    LRUWriteEn = 1'b0; SetValid = 1'b0;
    check("q_1000", q_l, 4'b1000);
    check("rand_c0", victim_l, 4'b0001);
    check("rr_rand_c3", victim_r, 4'b1000);
    LockWay = 4'b0101;
    #1;
    check("rand_c0_skip", victim_l, 4'b0010);

    // zero seed load maps to SEED in LFSR mode
    SeedLoad = 1'b1; SeedVal = 4'b0000;
    tick();
    SeedLoad = 1'b0;
    check("seed0_q", q_l, 4'b1111);
    check("rr_seed0_q", q_r, 4'b0000);

    // wrap-around and all-locked
    ValidWay = 4'b1111; LockWay = 4'b1000;
    #1;
    check("wrap_victim", victim_l, 4'b0001);
    check("wrap_novictim", {3'b000, novic_l}, 4'b0000);
    LockWay = 4'b1111;
    #1;
    check("all_locked_victim", victim_l, 4'b0000);
    check("all_locked_novictim", {3'b000, novic_l}, 4'b0001);
    check("rr_all_locked", victim_r, 4'b0000);
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    tick();
    LRUWriteEn = 1'b0; SetValid = 1'b0;
    check("locked_adv_q", q_l, 4'b0111);
    check("rr_locked_adv_q", q_r, 4'b0001);

    // flush suppresses both advance and invalidate
    LRUWriteEn = 1'b1; SetValid = 1'b1; FlushStage = 1'b1; InvalidateCache = 1'b1;
    tick();
    LRUWriteEn = 1'b0; SetValid = 1'b0; FlushStage = 1'b0; InvalidateCache = 1'b0;
    check("flush_q", q_l, 4'b0111);
    check("rr_flush_q", q_r, 4'b0001);

    // seed load outranks invalidate
    SeedLoad = 1'b1; InvalidateCache = 1'b1; SeedVal = 4'b0101;
    tick();
    SeedLoad = 1'b0; InvalidateCache = 1'b0;
    check("seedload_q", q_l, 4'b0101);
    check("rr_seedload_q", q_r, 4'b0101);
    InvalidateCache = 1'b1;
    tick();
    InvalidateCache = 1'b0;
    check("inval_q", q_l, 4'b1111);
    check("rr_inval_q", q_r, 4'b0000);

    // round-robin: 5 advances from reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; LockWay = 4'b0000; ValidWay = 4'b1111;
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    repeat (5) tick();
    LRUWriteEn = 1'b0; SetValid = 1'b0;
    check("rr_adv5_q", q_r, 4'b0001);
    check("rr_adv5_victim", victim_r, 4'b0010);
    check("lfsr_adv5_q", q_l, 4'b0100);
    InvalidateCache = 1'b1;
    tick();
    InvalidateCache = 1'b0;
    check("rr_inval2_q", q_r, 4'b0000);

    // reset beats a simultaneous advance
    LRUWriteEn = 1'b1; SetValid = 1'b1;
    tick();
    check("pre_reset_q", q_l, 4'b0111);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; LRUWriteEn = 1'b0; SetValid = 1'b0;
    check("reset_adv_q", q_l, 4'b1111);
    check("rr_reset_adv_q", q_r, 4'b0000);

    // random legality sweep
    for (int n = 0; n < 10000; n++) begin
      ValidWay        = 4'($urandom);
      LockWay         = ($urandom_range(0, 7) == 0) ? 4'b1111 : 4'($urandom);
      LRUWriteEn      = 1'($urandom);
      SetValid        = 1'($urandom);
      FlushStage      = ($urandom_range(0, 7) == 0);
      SeedLoad        = ($urandom_range(0, 63) == 0);
      SeedVal         = 4'($urandom);
      InvalidateCache = ($urandom_range(0, 63) == 0);
      #1;
      check("rand_legal", {3'b000, legal(victim_l, novic_l, q_l, 1'b1)}, 4'b0001);
      check("rr_rand_legal", {3'b000, legal(victim_r, novic_r, q_r, 1'b0)}, 4'b0001);
      tick();
    end
    LRUWriteEn = 1'b0; SetValid = 1'b0; FlushStage = 1'b0;
    SeedLoad = 1'b0; InvalidateCache = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
